// File: rtl/aq_f_sram_pkg.sv
// Shared constants for the single-port SRAM controller family.
package aq_f_sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/aq_f_spsram_ctl_if.sv
// User-side bus of the single-port SRAM controller (CEN/GWEN/WEN active-low).
interface aq_f_spsram_ctl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  QVLD;
  logic                  INIT_BUSY;

  modport master (
    output A, CEN, GWEN, WEN, D,
    input  Q, QVLD, INIT_BUSY
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D,
    output Q, QVLD, INIT_BUSY
  );
endinterface

// File: rtl/fpga_ram.sv
// Single-port RAM primitive: registered address, write-first read of the addressed entry.
module fpga_ram #(
  parameter int WRAP_SIZE  = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WRAP_SIZE-1:0]  din_i,
  input  logic                  we_i,
  output logic [WRAP_SIZE-1:0]  dout_o
);
  logic [WRAP_SIZE-1:0]  mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  // NOTE: the array has no reset; the controller's INIT state clears it entry by entry.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= din_i;
    addr_q <= addr_i;
  end

  assign dout_o = mem[addr_q];
endmodule

// File: rtl/aq_f_spsram_ctl.sv
// Single-port SRAM controller: post-reset clear, address hold, bit-masked writes, optional output register.
module aq_f_spsram_ctl
  import aq_f_sram_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 10,
  parameter int                   DATA_WIDTH = 64,
  parameter int                   WRAP_SIZE  = 1,
  parameter int                   OUT_REG    = 0,
  parameter int                   INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL  = '0
) (
  input logic             CLK,
  input logic             RST,
  aq_f_spsram_ctl_if.slave bus
);
  localparam state_e RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_we, ram_din, ram_dout;
  logic                  init_busy, access;

  assign init_busy = (state_q == ST_INIT);
  assign access    = !RST && !bus.CEN && !init_busy;

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rd_vld_d = access && bus.GWEN;
    ram_addr = addr_q;
    ram_din  = bus.D;
    ram_we   = '0;
    if (init_busy) begin
      ram_addr = cnt_q;
      ram_din  = INIT_VAL;
      ram_we   = RST ? '0 : '1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_READY;
    end else if (access) begin
      ram_addr = bus.A;
      addr_d   = bus.A;
      if (!bus.GWEN) ram_we = ~bus.WEN;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    logic [WRAP_SIZE-1:0] bit_dout;

    fpga_ram #(
      .WRAP_SIZE (WRAP_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clk   (CLK),
      .addr_i(ram_addr),
      .din_i ({WRAP_SIZE{ram_din[i]}}),
      .we_i  (ram_we[i]),
      .dout_o(bit_dout)
    );

    assign ram_dout[i] = bit_dout[0];
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_q;
    logic                  vld_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        q_q   <= '0;
        vld_q <= 1'b0;
      end else begin
        q_q   <= ram_dout;
        vld_q <= rd_vld_q;
      end
    end

    assign bus.Q    = q_q;
    assign bus.QVLD = vld_q;
  end else begin : g_no_out_reg
    assign bus.Q    = ram_dout;
    assign bus.QVLD = rd_vld_q;
  end

  assign bus.INIT_BUSY = init_busy;
endmodule

// File: tb/tb_aq_f_spsram_ctl.sv
// Directed bench: one controller without and one with the output register, driven in lockstep.
module tb_aq_f_spsram_ctl;
  localparam int              AW       = 4;
  localparam int              DW       = 64;
  localparam int              DEPTH    = 16;
  localparam logic [DW-1:0]   INIT_VAL = 64'h0000_0000_5A5A_C3C3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a;
  logic          cen, gwen;
  logic [DW-1:0] wen, d;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  aq_f_spsram_ctl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  aq_f_spsram_ctl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.A = a;  assign bus0.CEN = cen;  assign bus0.GWEN = gwen;
  assign bus0.WEN = wen;  assign bus0.D = d;
  assign bus1.A = a;  assign bus1.CEN = cen;  assign bus1.GWEN = gwen;
  assign bus1.WEN = wen;  assign bus1.D = d;

  aq_f_spsram_ctl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(1),
    .OUT_REG(0), .INIT_EN(1), .INIT_VAL(INIT_VAL)
  ) dut0 (.CLK(clk), .RST(rst), .bus(bus0));

  aq_f_spsram_ctl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(1),
    .OUT_REG(1), .INIT_EN(1), .INIT_VAL(INIT_VAL)
  ) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  function automatic logic [DW-1:0] pat(input int k);
    return {16{k[3:0]}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cen  = 1'b1;
    gwen = 1'b1;
    wen  = '1;
    d    = '0;
  endtask

  // Counts INIT_BUSY cycles from the current sample point; leaves the bus idle once clear ends.
  task automatic wait_clear(input string name);
    int   busy_cycles;
    logic qvld_seen;
    busy_cycles = 0;
    qvld_seen   = 1'b0;
    while (bus0.INIT_BUSY === 1'b1 && busy_cycles < 64) begin
      if (bus0.QVLD !== 1'b0 || bus1.QVLD !== 1'b0) qvld_seen = 1'b1;
      busy_cycles++;
      step();
    end
    idle();
    checks++;
    if (busy_cycles != DEPTH) begin
      errors++;
      $display("FAIL %s_len: busy cycles %0d, expected %0d", name, busy_cycles, DEPTH);
    end
    checks++;
    if (bus1.INIT_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy1: INIT_BUSY %b, expected 0", name, bus1.INIT_BUSY);
    end
    checks++;
    if (qvld_seen) begin
      errors++;
      $display("FAIL %s_qvld: QVLD seen 1 during clear, expected 0", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a   = '0;
    idle();
    step();
    step();
    checks++;
    if (bus0.INIT_BUSY !== 1'b1 || bus1.INIT_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b, expected 1/1", bus0.INIT_BUSY, bus1.INIT_BUSY);
    end
    checks++;
    if (bus0.QVLD !== 1'b0 || bus1.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL reset_qvld: got %b/%b, expected 0/0", bus0.QVLD, bus1.QVLD);
    end
    checks++;
    if (bus1.Q !== '0) begin
      errors++;
      $display("FAIL reset_q1: got %h, expected 0", bus1.Q);
    end
  endtask

  // Writes to A=0 are attempted throughout the clear and must be dropped.
  task automatic test_init_clear();
    a    = '0;
    cen  = 1'b0;
    gwen = 1'b0;
    wen  = '0;
    d    = ~INIT_VAL;
    rst  = 1'b0;
    wait_clear("init");
    step();
    step();
    checks++;
    if (bus0.Q !== INIT_VAL || bus1.Q !== INIT_VAL) begin
      errors++;
      $display("FAIL init_q: got %h/%h, expected %h", bus0.Q, bus1.Q, INIT_VAL);
    end
    checks++;
    if (bus0.QVLD !== 1'b0 || bus1.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL init_idle_qvld: got %b/%b, expected 0/0", bus0.QVLD, bus1.QVLD);
    end
  endtask

  // Reads every entry on consecutive cycles with WEN=0 and D=all-ones, which reads must ignore.
  task automatic test_read_all();
    for (int i = 0; i < DEPTH; i++) begin
      a    = i[AW-1:0];
      cen  = 1'b0;
      gwen = 1'b1;
      wen  = '0;
      d    = '1;
      step();
      checks++;
      if (bus0.Q !== INIT_VAL || bus0.QVLD !== 1'b1) begin
        errors++;
        $display("FAIL read_all0[%0d]: q=%h vld=%b, expected q=%h vld=1", i, bus0.Q, bus0.QVLD, INIT_VAL);
      end
      if (i > 0) begin
        checks++;
        if (bus1.Q !== INIT_VAL || bus1.QVLD !== 1'b1) begin
          errors++;
          $display("FAIL read_all1[%0d]: q=%h vld=%b, expected q=%h vld=1", i - 1, bus1.Q, bus1.QVLD, INIT_VAL);
        end
      end
    end
    idle();
    step();
    checks++;
    if (bus1.Q !== INIT_VAL || bus1.QVLD !== 1'b1 || bus0.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL read_all_tail: q1=%h vld1=%b vld0=%b, expected q1=%h vld1=1 vld0=0",
               bus1.Q, bus1.QVLD, bus0.QVLD, INIT_VAL);
    end
  endtask

  task automatic test_write_mask();
    a    = 4'd5;
    cen  = 1'b0;
    gwen = 1'b0;
    d    = '1;
    wen  = 64'hFFFF_FFFF_0000_0000;
    step();
    idle();
    checks++;
    if (bus0.Q !== 64'h0000_0000_FFFF_FFFF || bus0.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL wr_mask_a5: q=%h vld=%b, expected q=00000000ffffffff vld=0", bus0.Q, bus0.QVLD);
    end
    step();
    checks++;
    if (bus1.Q !== 64'h0000_0000_FFFF_FFFF || bus1.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL wr_mask_a5_oreg: q=%h vld=%b, expected q=00000000ffffffff vld=0", bus1.Q, bus1.QVLD);
    end
    a    = 4'd6;
    cen  = 1'b0;
    gwen = 1'b0;
    d    = 64'h0123_4567_89AB_CDEF;
    wen  = 64'h00FF_00FF_00FF_00FF;
    step();
    idle();
    checks++;
    if (bus0.Q !== 64'h0100_4500_895A_CDC3 || bus0.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL wr_mask_a6: q=%h vld=%b, expected q=01004500895acdc3 vld=0", bus0.Q, bus0.QVLD);
    end
    a    = 4'd5;
    cen  = 1'b0;
    gwen = 1'b1;
    step();
    a = 4'd6;
    checks++;
    if (bus0.Q !== 64'h0000_0000_FFFF_FFFF || bus0.QVLD !== 1'b1) begin
      errors++;
      $display("FAIL rd_a5: q=%h vld=%b, expected q=00000000ffffffff vld=1", bus0.Q, bus0.QVLD);
    end
    step();
    idle();
    checks++;
    if (bus0.Q !== 64'h0100_4500_895A_CDC3 || bus0.QVLD !== 1'b1) begin
      errors++;
      $display("FAIL rd_a6: q=%h vld=%b, expected q=01004500895acdc3 vld=1", bus0.Q, bus0.QVLD);
    end
  endtask

  // Reads A=1,2,3 back to back, then idles with A moved away: Q must hold entry 3.
  task automatic test_back_to_back();
    logic          exp_v0, exp_v1;
    logic [DW-1:0] exp_q0, exp_q1;
    for (int k = 1; k <= 3; k++) begin
      a    = k[AW-1:0];
      cen  = 1'b0;
      gwen = 1'b0;
      wen  = '0;
      d    = pat(k);
      step();
    end
    for (int r = 0; r < 6; r++) begin
      if (r < 3) begin
        a    = 4'(r + 1);
        cen  = 1'b0;
        gwen = 1'b1;
      end else begin
        a    = 4'd0;
        cen  = 1'b1;
      end
      step();
      exp_v0 = (r < 3);
      exp_q0 = pat((r < 2 ? r : 2) + 1);
      exp_v1 = (r >= 1 && r <= 3);
      exp_q1 = pat((r < 3 ? r : 3));
      checks++;
      if (bus0.Q !== exp_q0 || bus0.QVLD !== exp_v0) begin
        errors++;
        $display("FAIL b2b0[%0d]: q=%h vld=%b, expected q=%h vld=%b", r, bus0.Q, bus0.QVLD, exp_q0, exp_v0);
      end
      checks++;
      if (bus1.QVLD !== exp_v1 || (r > 0 && bus1.Q !== exp_q1)) begin
        errors++;
        $display("FAIL b2b1[%0d]: q=%h vld=%b, expected q=%h vld=%b", r, bus1.Q, bus1.QVLD, exp_q1, exp_v1);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_op();
    a    = 4'd2;
    cen  = 1'b0;
    gwen = 1'b1;
    step();
    rst = 1'b1;
    idle();
    step();
    checks++;
    if (bus0.QVLD !== 1'b0 || bus1.QVLD !== 1'b0) begin
      errors++;
      $display("FAIL rst_read_qvld: got %b/%b, expected 0/0", bus0.QVLD, bus1.QVLD);
    end
    checks++;
    if (bus1.Q !== '0 || bus0.INIT_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_state: q1=%h busy=%b, expected q1=0 busy=1", bus1.Q, bus0.INIT_BUSY);
    end
    rst = 1'b0;
    repeat (7) step();
    checks++;
    if (bus0.INIT_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_busy: got %b, expected 1", bus0.INIT_BUSY);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear("restart");
    a    = 4'd2;
    cen  = 1'b0;
    gwen = 1'b1;
    step();
    a = 4'd5;
    checks++;
    if (bus0.Q !== INIT_VAL || bus0.QVLD !== 1'b1) begin
      errors++;
      $display("FAIL recleared_a2: q=%h vld=%b, expected q=%h vld=1", bus0.Q, bus0.QVLD, INIT_VAL);
    end
    step();
    idle();
    checks++;
    if (bus0.Q !== INIT_VAL || bus0.QVLD !== 1'b1) begin
      errors++;
      $display("FAIL recleared_a5: q=%h vld=%b, expected q=%h vld=1", bus0.Q, bus0.QVLD, INIT_VAL);
    end
  endtask

  initial begin
    test_reset();
    test_init_clear();
    test_read_all();
    test_write_mask();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
